// File: rtl/alwaysff_unpacked_pkg.sv
// alwaysff_unpacked_pkg: shared types and default sizes for the round-robin write arbiter slice.
package alwaysff_unpacked_pkg;
   localparam int NREQ_DEF = 4;
   localparam int DEPTH_DEF = 8;
   localparam int WIDTH_DEF = 1;
   localparam int IDX_W = $clog2(DEPTH_DEF);
   localparam int PTR_W = $clog2(NREQ_DEF);
   typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;
   typedef logic [WIDTH_DEF-1:0] elem_t;
endpackage

// File: rtl/alwaysff_unpacked_rrwritearbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the pointer moves past the winner only on an enabled grant.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic            i_clk,
   input  logic            i_arst_n,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_en,
   output logic [NREQ-1:0] o_gnt
);
   localparam int PW = $clog2(NREQ);
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   nxt;
   logic [PW-1:0]   r;
   logic [NREQ-1:0] gnt;
   logic            hit;
   always_comb begin
      gnt = '0;
      nxt = ptr;
      hit = 1'b0;
      r = '0;
      for (int k = 0; k < NREQ; k++) begin
         r = PW'((int'(ptr) + k) % NREQ);
         if (!hit && i_req[r]) begin
            hit = 1'b1;
            gnt[r] = 1'b1;
            nxt = PW'((int'(ptr) + k + 1) % NREQ);
         end
      end
   end
   // Gated by reset as well so no grant leaks out while reset is held.
   assign o_gnt = (i_en && i_arst_n) ? gnt : '0;
   always_ff @(posedge i_clk or negedge i_arst_n)
      if (!i_arst_n) ptr <= '0;
      else if (i_en && hit) ptr <= nxt;
endmodule

// File: rtl/alwaysff_unpacked_rrwritearbiter.sv
// alwaysff_unpacked_rrwritearbiter: round-robin single-element writes into an unpacked register bank,
// with a one-element-per-cycle clear sweep that takes priority over requesters.
module alwaysff_unpacked_rrwritearbiter
   import alwaysff_unpacked_pkg::*;
#(
   parameter int               NREQ    = 4,
   parameter int               DEPTH   = 8,
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic                     i_clk,
   input  logic                     i_arst_n,
   input  logic [NREQ-1:0]          i_req,
   input  logic [$clog2(DEPTH)-1:0] i_idx [NREQ],
   input  logic [WIDTH-1:0]         i_data [NREQ],
   input  logic                     i_clr,
   output logic [NREQ-1:0]          o_gnt,
   output logic                     o_busy,
   output logic [WIDTH-1:0]         o_x [DEPTH]
);
   localparam int IW = $clog2(DEPTH);
   state_t           state;
   logic [IW-1:0]    sw_idx;
   logic             en;
   logic             wr;
   logic [IW-1:0]    wr_idx;
   logic [WIDTH-1:0] wr_data;
   assign en = (state == IDLE) && !i_clr;
   assign o_busy = (state == SWEEP);
   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_req    (i_req),
      .i_en     (en),
      .o_gnt    (o_gnt)
   );
   always_comb begin
      wr = 1'b0;
      wr_idx = '0;
      wr_data = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (o_gnt[r]) begin
            wr = 1'b1;
            wr_idx = i_idx[r];
            wr_data = i_data[r];
         end
      end
   end
   always_ff @(posedge i_clk or negedge i_arst_n)
      if (!i_arst_n) begin
         state <= IDLE;
         sw_idx <= '0;
      end else if (state == IDLE && i_clr) begin
         state <= SWEEP;
         sw_idx <= '0;
      end else if (state == SWEEP) begin
         sw_idx <= IW'(sw_idx + 1'b1);
         if (sw_idx == IW'(DEPTH - 1)) state <= IDLE;
      end
   // Out-of-range write indices match no element, so they are dropped silently.
   always_ff @(posedge i_clk or negedge i_arst_n)
      if (!i_arst_n) begin
         foreach (o_x[e]) o_x[e] <= '0;
      end else begin
         foreach (o_x[e])
            if (state == SWEEP && sw_idx == IW'(e)) o_x[e] <= CLR_VAL;
            else if (wr && wr_idx == IW'(e)) o_x[e] <= wr_data;
      end
endmodule

// File: tb/tb_alwaysff_unpacked_rrwritearbiter.sv
// tb_alwaysff_unpacked_rrwritearbiter: directed vector table plus hand-written sweep and reset sequences.
module tb_alwaysff_unpacked_rrwritearbiter;
   import alwaysff_unpacked_pkg::*;
   typedef struct {
      logic [3:0]  req;
      logic [11:0] idx;
      logic [3:0]  dat;
      logic [3:0]  gnt;
      int          ci;
      logic        cv;
   } vec_t;
   localparam logic [11:0] SEQ = {3'd3, 3'd2, 3'd1, 3'd0};
   logic             clk;
   logic             rst_n;
   logic [3:0]       req;
   logic [IDX_W-1:0] idx [4];
   elem_t            data [4];
   logic             clr;
   logic [3:0]       gnt;
   logic             busy;
   elem_t            x [8];
   int               n_chk;
   int               n_fail;
   vec_t             tbl [12];
   alwaysff_unpacked_rrwritearbiter dut (
      .i_clk    (clk),
      .i_arst_n (rst_n),
      .i_req    (req),
      .i_idx    (idx),
      .i_data   (data),
      .i_clr    (clr),
      .o_gnt    (gnt),
      .o_busy   (busy),
      .o_x      (x)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [7:0] xpack();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = x[i][0];
      return v;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic drive(input logic [3:0] rq, input logic [11:0] ix, input logic [3:0] d, input logic c);
      req = rq;
      for (int r = 0; r < 4; r++) begin
         idx[r] = ix[3*r +: 3];
         data[r] = d[r];
      end
      clr = c;
   endtask
   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      drive(4'b1111, SEQ, 4'b1111, 1'b0);
      tbl[0]  = '{4'b0000, 12'd0, 4'b0000, 4'b0000, 0, 1'b0};
      tbl[1]  = '{4'b1111, SEQ, 4'b1111, 4'b0001, 0, 1'b1};
      tbl[2]  = '{4'b1111, SEQ, 4'b1111, 4'b0010, 1, 1'b1};
      tbl[3]  = '{4'b1111, SEQ, 4'b1111, 4'b0100, 2, 1'b1};
      tbl[4]  = '{4'b1111, SEQ, 4'b1111, 4'b1000, 3, 1'b1};
      tbl[5]  = '{4'b1111, SEQ, 4'b1111, 4'b0001, 0, 1'b1};
      tbl[6]  = '{4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 4'b0100, 4'b0100, 5, 1'b1};
      tbl[7]  = '{4'b1011, {3'd7, 9'd0}, 4'b1000, 4'b1000, 7, 1'b1};
      tbl[8]  = '{4'b0010, {6'd0, 3'd4, 3'd0}, 4'b0010, 4'b0010, 4, 1'b1};
      tbl[9]  = '{4'b0001, 12'd0, 4'b0000, 4'b0001, 0, 1'b0};
      tbl[10] = '{4'b0101, {3'd0, 3'd6, 6'd0}, 4'b0101, 4'b0100, 6, 1'b1};
      tbl[11] = '{4'b0001, 12'd0, 4'b0001, 4'b0001, 0, 1'b1};
      #2;
      chk("reset x", 32'(xpack()), 32'h00);
      chk("reset gnt", 32'(gnt), 32'h0);
      chk("reset busy", 32'(busy), 32'h0);
      #5;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].req, tbl[i].idx, tbl[i].dat, 1'b0);
         #1;
         chk($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d x[%0d]", i, tbl[i].ci), 32'(x[tbl[i].ci]), 32'(tbl[i].cv));
      end
      chk("all ones", 32'(xpack()), 32'hff);
      // Sweep with every requester held; a second clr pulse mid-sweep must not restart it.
      drive(4'b1111, SEQ, 4'b1111, 1'b1);
      #1;
      chk("clr cycle gnt", 32'(gnt), 32'h0);
      chk("clr cycle busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      for (int k = 0; k < 8; k++) begin
         clr = (k == 2);
         #1;
         chk($sformatf("sweep%0d busy", k), 32'(busy), 32'h1);
         chk($sformatf("sweep%0d gnt", k), 32'(gnt), 32'h0);
         @(posedge clk);
         #1;
         chk($sformatf("sweep%0d x[%0d]", k, k), 32'(x[k]), 32'h0);
         if (k < 7) chk($sformatf("sweep%0d x[%0d]", k, k + 1), 32'(x[k + 1]), 32'h1);
      end
      drive(4'b1111, {3'd3, 3'd2, 3'd5, 3'd0}, 4'b1111, 1'b0);
      #1;
      chk("post sweep busy", 32'(busy), 32'h0);
      chk("post sweep gnt", 32'(gnt), 32'b0010);
      @(posedge clk);
      #1;
      chk("post sweep x[5]", 32'(x[5]), 32'h1);
      // clr and a request in the same idle cycle: clear wins, no write.
      drive(4'b0001, 12'd0, 4'b0001, 1'b1);
      #1;
      chk("clr+req gnt", 32'(gnt), 32'h0);
      @(posedge clk);
      #1;
      chk("clr+req busy", 32'(busy), 32'h1);
      chk("clr+req x[0]", 32'(x[0]), 32'h0);
      drive(4'b0000, 12'd0, 4'b0000, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("mid sweep busy", 32'(busy), 32'h1);
      chk("mid sweep x[5]", 32'(x[5]), 32'h1);
      #2;
      rst_n = 1'b0;
      drive(4'b1111, SEQ, 4'b1111, 1'b0);
      #1;
      chk("async rst x", 32'(xpack()), 32'h00);
      chk("async rst busy", 32'(busy), 32'h0);
      chk("async rst gnt", 32'(gnt), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("after rst busy", 32'(busy), 32'h0);
      chk("after rst gnt", 32'(gnt), 32'b0001);
      @(posedge clk);
      #1;
      chk("after rst x[0]", 32'(x[0]), 32'h1);
      chk("after rst gnt2", 32'(gnt), 32'b0010);
      @(posedge clk);
      #1;
      chk("after rst x[1]", 32'(x[1]), 32'h1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
